// File: rtl/button_conditioner.sv
// Button conditioner: debounces an already-synchronized button level and
// derives rise/fall pulses, a one-shot long-press pulse and a press counter.
// Every output comes straight from a flop. Reset is asynchronous and clears
// all state, so a reset can never produce a pulse.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CLKS   = 250000,
  parameter int unsigned LONG_PRESS_CLKS = 25000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sync_in,
  output logic       o_level,
  output logic       o_rise,
  output logic       o_fall,
  output logic       o_long,
  output logic [7:0] o_press_count
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CLKS) + 1;
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CLKS) + 1;

  // The debounce counter holds the number of disagreeing samples seen so far.
  // When it already holds DEBOUNCE_CLKS-1, the next disagreeing sample is the
  // qualifying one.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CLKS - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  // The hold counter is cleared on the rise edge and counts every edge after
  // it. It therefore holds LONG_PRESS_CLKS-1 just before the edge that fires.
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_CLKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = {HOLD_W{1'b1}};

  typedef enum logic [1:0] {
    S_LOW,
    S_PEND_HIGH,
    S_HIGH,
    S_PEND_LOW
  } state_e;

  state_e            state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              long_q, long_d;
  logic [7:0]        press_q, press_d;

  // Next-state decode: debounce FSM, edge pulses, hold timer and press count
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;

    unique case (state_q)
      S_LOW: begin
        if (i_sync_in) begin
          state_d  = S_PEND_HIGH;
          db_cnt_d = DB_ONE;
        end else begin
          db_cnt_d = '0;
        end
      end

      S_PEND_HIGH: begin
        if (!i_sync_in) begin
          // The high run broke before qualifying, so it was only a glitch.
          state_d  = S_LOW;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = S_HIGH;
          db_cnt_d = '0;
          rise_d   = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end

      S_HIGH: begin
        if (!i_sync_in) begin
          state_d  = S_PEND_LOW;
          db_cnt_d = DB_ONE;
        end else begin
          db_cnt_d = '0;
        end
      end

      S_PEND_LOW: begin
        if (i_sync_in) begin
          state_d  = S_HIGH;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = S_LOW;
          db_cnt_d = '0;
          fall_d   = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end

      default: begin
        state_d  = S_LOW;
        db_cnt_d = '0;
      end
    endcase

    level_d = (state_d == S_HIGH) || (state_d == S_PEND_LOW);

    // The hold timer keeps running through S_PEND_LOW because the debounced
    // level is still high there. It saturates so it can never wrap back to
    // the firing value.
    hold_d = hold_q;
    if (rise_d) begin
      hold_d = '0;
    end else if (level_q && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_ONE;
    end

    // When the fall and the long-press threshold land on the same edge, the
    // fall takes priority. The equality test fires only once per press,
    // because the counter moves past HOLD_FIRE and never comes back.
    long_d = level_q && !fall_d && (hold_q == HOLD_FIRE);

    press_d = press_q;
    if (rise_d) begin
      press_d = press_q + 8'd1;
    end
  end

  // State and output registers; reset clears everything without a clock edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_LOW;
      db_cnt_q <= '0;
      hold_q   <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      long_q   <= 1'b0;
      press_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      hold_q   <= hold_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      long_q   <= long_d;
      press_q  <= press_d;
    end
  end

  assign o_level       = level_q;
  assign o_rise        = rise_q;
  assign o_fall        = fall_q;
  assign o_long        = long_q;
  assign o_press_count = press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CLKS=4 and LONG_PRESS_CLKS=10.
// A run-length reference model predicts the outputs for every clock. Each
// prediction is queued when the input is driven and compared once the edge
// has happened. A table of input segments also gives hand-derived results
// for each segment, and short hand-written sequences cover the wrap-around
// and asynchronous-reset corner cases.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int LP = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sync_in = 1'b0;
  logic       o_level, o_rise, o_fall, o_long;
  logic [7:0] o_press_count;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CLKS  (DB),
    .LONG_PRESS_CLKS(LP)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sync_in    (sync_in),
    .o_level      (o_level),
    .o_rise       (o_rise),
    .o_fall       (o_fall),
    .o_long       (o_long),
    .o_press_count(o_press_count)
  );

  typedef struct packed {
    logic       level;
    logic       rise;
    logic       fall;
    logic       lng;
    logic [7:0] cnt;
  } obs_t;

  typedef struct {
    bit lvl;
    int cycles;
    int exp_level;
    int exp_cnt;
    int exp_rise;
    int exp_fall;
    int exp_long;
  } seg_t;

  localparam int NSEG = 16;

  obs_t exp_q[$];
  seg_t tbl[NSEG];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model state. m_run counts consecutive samples that differ from
  // the debounced level. m_age counts the edges seen since the last rise.
  int m_level, m_run, m_age, m_cnt;
  int seen_rise, seen_fall, seen_long;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0;
    m_run   = 0;
    m_age   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_edge(input bit s, output obs_t e);
    e = '0;
    if (m_level == 1) m_age++;
    if (int'(s) != m_level) m_run++;
    else m_run = 0;
    if (m_run == DB) begin
      m_run = 0;
      if (m_level == 0) begin
        m_level = 1;
        m_age   = 0;
        m_cnt   = (m_cnt + 1) % 256;
        e.rise  = 1'b1;
      end else begin
        m_level = 0;
        e.fall  = 1'b1;
      end
    end
    e.lng   = (m_level == 1) && (m_age == LP);
    e.level = (m_level == 1);
    e.cnt   = 8'(m_cnt);
  endtask

  // Drive one sample, queue the prediction, and compare just after the edge
  task automatic step(input bit s);
    obs_t e, a;
    sync_in = s;
    model_edge(s, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    a = {o_level, o_rise, o_fall, o_long, o_press_count};
    e = exp_q.pop_front();
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL cycle_%0d: got lvl=%b rise=%b fall=%b long=%b cnt=%0d, expected lvl=%b rise=%b fall=%b long=%b cnt=%0d",
               cyc, a.level, a.rise, a.fall, a.lng, a.cnt,
               e.level, e.rise, e.fall, e.lng, e.cnt);
    end
    seen_rise += int'(o_rise);
    seen_fall += int'(o_fall);
    seen_long += int'(o_long);
  endtask

  initial begin
    // lvl, cycles, level, count, rises, falls, longs
    tbl[0]  = '{1'b0,  5, 0, 0, 0, 0, 0};  // idle low
    tbl[1]  = '{1'b1,  3, 0, 0, 0, 0, 0};  // 3-cycle glitch high
    tbl[2]  = '{1'b0,  1, 0, 0, 0, 0, 0};  // 1 low breaks it
    tbl[3]  = '{1'b1,  4, 1, 1, 1, 0, 0};  // rise on the 4th high edge
    tbl[4]  = '{1'b1, 20, 1, 1, 0, 0, 1};  // long press: exactly one long
    tbl[5]  = '{1'b0,  4, 0, 1, 0, 1, 0};  // release: fall, no second long
    tbl[6]  = '{1'b1,  4, 1, 2, 1, 0, 0};  // press 2
    tbl[7]  = '{1'b1,  5, 1, 2, 0, 0, 0};  // hold edges 1..5
    tbl[8]  = '{1'b0,  4, 0, 2, 0, 1, 0};  // short press, fall at edge 9
    tbl[9]  = '{1'b1,  4, 1, 3, 1, 0, 0};  // press 3
    tbl[10] = '{1'b1,  6, 1, 3, 0, 0, 0};  // hold edges 1..6
    tbl[11] = '{1'b0,  4, 0, 3, 0, 1, 0};  // fall on edge 10: long suppressed
    tbl[12] = '{1'b1,  4, 1, 4, 1, 0, 0};  // press 4
    tbl[13] = '{1'b0,  3, 1, 4, 0, 0, 0};  // low glitch while high
    tbl[14] = '{1'b1, 10, 1, 4, 0, 0, 1};  // hold keeps counting: long at edge 10
    tbl[15] = '{1'b0,  4, 0, 4, 0, 1, 0};  // release

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_level", int'(o_level), 0);
    check("reset_rise",  int'(o_rise),  0);
    check("reset_fall",  int'(o_fall),  0);
    check("reset_long",  int'(o_long),  0);
    check("reset_count", int'(o_press_count), 0);
    rst_n = 1'b1;

    // Table-driven segments
    for (int i = 0; i < NSEG; i++) begin
      seen_rise = 0;
      seen_fall = 0;
      seen_long = 0;
      for (int c = 0; c < tbl[i].cycles; c++) step(tbl[i].lvl);
      check($sformatf("seg%0d_level", i), int'(o_level), tbl[i].exp_level);
      check($sformatf("seg%0d_count", i), int'(o_press_count), tbl[i].exp_cnt);
      check($sformatf("seg%0d_rises", i), seen_rise, tbl[i].exp_rise);
      check($sformatf("seg%0d_falls", i), seen_fall, tbl[i].exp_fall);
      check($sformatf("seg%0d_longs", i), seen_long, tbl[i].exp_long);
    end

    // Press counter wraps: 252 more presses bring the total to 256
    for (int p = 0; p < 252; p++) begin
      for (int c = 0; c < DB; c++) step(1'b1);
      if (p == 250) check("count_255", int'(o_press_count), 255);
      if (p == 251) begin
        check("wrap_rise",  int'(o_rise), 1);
        check("wrap_count", int'(o_press_count), 0);
      end
      for (int c = 0; c < DB; c++) step(1'b0);
    end

    // Reset asserted mid-press takes effect without a clock edge
    for (int c = 0; c < DB + 2; c++) step(1'b1);
    check("pre_reset_level", int'(o_level), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_level", int'(o_level), 0);
    check("async_rise",  int'(o_rise),  0);
    check("async_fall",  int'(o_fall),  0);
    check("async_long",  int'(o_long),  0);
    check("async_count", int'(o_press_count), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("held_reset_level", int'(o_level), 0);
    check("held_reset_fall",  int'(o_fall),  0);
    rst_n = 1'b1;

    // Input already high at release: full qualification still required
    seen_rise = 0;
    for (int c = 0; c < DB - 1; c++) step(1'b1);
    check("post_reset_no_early_rise", int'(o_level), 0);
    step(1'b1);
    check("post_reset_rise",  seen_rise, 1);
    check("post_reset_count", int'(o_press_count), 1);
    for (int c = 0; c < DB; c++) step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CLKS, default 250000, is the number of consecutive disagreeing samples required to change the debounced level (10 ms at 25 MHz); legal range 2 to 2^24.
REQ-002 Parameter LONG_PRESS_CLKS, default 25000000, is the number of cycles the debounced level must stay high before a long-press pulse (1 s at 25 MHz); it SHALL be greater than DEBOUNCE_CLKS.
REQ-003 Port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port i_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 Port i_sync_in, input, 1 bit: button level, active-high, already synchronized to i_clk by the upstream 2-FF synchronizer.
REQ-006 Port o_level, output, 1 bit: debounced button level.
REQ-007 Port o_rise, output, 1 bit: one-cycle pulse when o_level goes 0->1.
REQ-008 Port o_fall, output, 1 bit: one-cycle pulse when o_level goes 1->0.
REQ-009 Port o_long, output, 1 bit: one-cycle pulse when a press reaches LONG_PRESS_CLKS.
REQ-010 Port o_press_count, output, 8 bits: number of debounced presses (rises), modulo 256.

Function
REQ-011 The FSM SHALL have four states: S_LOW, S_PEND_HIGH, S_HIGH and S_PEND_LOW. o_level is 1 only in S_HIGH and S_PEND_LOW.
REQ-012 S_LOW: a sample of i_sync_in=1 moves the FSM to S_PEND_HIGH with the debounce counter set to 1; a sample of 0 keeps S_LOW with the counter at 0.
REQ-013 S_PEND_HIGH: a sample of 1 increments the counter; when DEBOUNCE_CLKS consecutive samples of 1 are reached, the FSM enters S_HIGH and clears the counter. A sample of 0 returns the FSM to S_LOW and clears the counter.
REQ-014 S_HIGH and S_PEND_LOW SHALL mirror REQ-012 and REQ-013 with the polarity inverted: DEBOUNCE_CLKS consecutive samples of 0 enter S_LOW.
REQ-015 Latency: o_level SHALL change on the same edge that samples the DEBOUNCE_CLKS-th consecutive differing value.
REQ-016 Any glitch shorter than DEBOUNCE_CLKS cycles SHALL produce no change on any output.
REQ-017 Edge pulses: o_rise and o_fall are registered and asserted high for exactly the one cycle in which o_level first shows its new value; they are never both high.
REQ-018 Hold counter: cleared on the edge where o_level rises; increments on every edge while o_level=1, including while in S_PEND_LOW; saturates.
REQ-019 o_long SHALL be high for exactly one cycle, on the LONG_PRESS_CLKS-th edge after the rise.
REQ-020 o_long SHALL fire at most once per press.
REQ-021 o_long SHALL NOT fire if o_level falls first.
REQ-022 If a fall and the long threshold occur on the same edge, the fall wins and o_long stays 0.
REQ-023 o_press_count SHALL increment by 1 on the edge that asserts o_rise, wrapping from 255 to 0.
REQ-024 Counter widths SHALL be $clog2 of the respective parameter plus 1; no counter may overflow or wrap at its maximum.

Reset
REQ-025 While i_rst_n=0: the FSM is forced to S_LOW; all counters are 0; o_level, o_rise, o_fall and o_long are 0; o_press_count is 0.
REQ-026 Reset assertion mid-debounce or mid-press SHALL take effect immediately, without waiting for a clock edge, and no pulse may be emitted because of reset.
REQ-027 After i_rst_n releases with i_sync_in already at 1, a full DEBOUNCE_CLKS qualification SHALL be required before o_level rises.

Verification (DEBOUNCE_CLKS=4, LONG_PRESS_CLKS=10)
REQ-028 Clean press: i_sync_in 0->1 held high -> o_level=1 and o_rise=1 on the 4th sampling edge; o_rise=0 on the next cycle; o_press_count=1.
REQ-029 Glitch: a 3-cycle high pulse, then low -> o_level, o_rise and o_press_count unchanged. A 3-high, 1-low, 4-high pattern -> rise on the 4th edge of the second high run.
REQ-030 Long press: hold high 20 cycles after rise -> o_long pulses exactly once, 10 edges after o_rise. Release -> o_fall pulses 4 edges later, with no second o_long.
REQ-031 Short press: rise, then release after 5 cycles -> o_fall pulses and o_long never asserts. Release timed so the fall edge coincides with the 10th hold edge -> o_long=0.
REQ-032 Wrap: 256 clean presses -> o_press_count reads 0 after the 256th rise.
REQ-033 Reset mid-press: assert i_rst_n=0 while o_level=1 -> all outputs 0 asynchronously. Release with input high -> rise after 4 edges.
